// File: rtl/mac_txq_if.sv
// Bus bundle for mac_txq: descriptor push port, source-memory read bus, MAC register bus and status.
// "master" is the queue engine side, "slave" is the surrounding system.
interface mac_txq_if #(
   parameter int SRC_AW = 11
);
   logic              desc_valid_i;
   logic [SRC_AW-1:0] desc_addr_i;
   logic [10:0]       desc_len_i;
   logic              desc_ready_o;

   logic [SRC_AW-1:0] src_adr_o;
   logic              src_stb_o;
   logic [31:0]       src_dat_i;
   logic              src_ack_i;

   logic [12:0]       mac_adr_o;
   logic [31:0]       mac_dat_o;
   logic [3:0]        mac_sel_o;
   logic              mac_stb_o;
   logic              mac_we_o;
   logic              mac_ack_i;
   logic              mac_txempty_i;

   logic              busy_o;
   logic              done_o;
   logic              err_o;
   logic [4:0]        qcount_o;

   modport master (
      input  desc_valid_i, desc_addr_i, desc_len_i, src_dat_i, src_ack_i,
             mac_ack_i, mac_txempty_i,
      output desc_ready_o, src_adr_o, src_stb_o, mac_adr_o, mac_dat_o, mac_sel_o,
             mac_stb_o, mac_we_o, busy_o, done_o, err_o, qcount_o
   );

   modport slave (
      output desc_valid_i, desc_addr_i, desc_len_i, src_dat_i, src_ack_i,
             mac_ack_i, mac_txempty_i,
      input  desc_ready_o, src_adr_o, src_stb_o, mac_adr_o, mac_dat_o, mac_sel_o,
             mac_stb_o, mac_we_o, busy_o, done_o, err_o, qcount_o
   );
endinterface

// File: rtl/mac_txq.sv
// Transmit queue: buffers frame descriptors and copies each frame word by word from source
// memory into the MAC buffer, then writes the length register to start transmission.
module mac_txq #(
   parameter int QDEPTH = 4,
   parameter int SRC_AW = 11
) (
   input  logic   clk_i,
   input  logic   rst_i,
   mac_txq_if.master bus
);
   localparam int PW = $clog2(QDEPTH);

   typedef enum logic [2:0] {
      IDLE, CHECK, WAITMAC, RD, WR, START, WAITLO, WAITHI
   } state_t;

   logic [SRC_AW-1:0] addr_mem [QDEPTH];
   logic [10:0]       len_mem  [QDEPTH];
   logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
   logic [4:0]        qcount_reg;
   logic              push, pop, desc_ready;

   state_t            state_reg;
   logic [SRC_AW-1:0] addr_reg;
   logic [10:0]       len_reg;
   logic [9:0]        words_reg, idx_reg, idx_next;
   logic [11:0]       len_plus;
   logic [SRC_AW-1:0] src_adr_reg;
   logic              src_stb_reg;
   logic [12:0]       mac_adr_reg;
   logic [31:0]       mac_dat_reg;
   logic              mac_stb_reg;
   logic              busy_reg, done_reg, err_reg;

   // Ready depends only on the stored count, so a full queue refuses even when a pop is due.
   assign desc_ready = (qcount_reg != 5'(QDEPTH));
   assign push       = bus.desc_valid_i && desc_ready;
   assign pop        = (state_reg == IDLE) && (qcount_reg != 5'd0);
   assign idx_next   = idx_reg + 10'd1;
   assign len_plus   = {1'b0, len_reg} + 12'd3;

   always_ff @(posedge clk_i) begin
      if (push) begin
         addr_mem[wr_ptr_reg] <= bus.desc_addr_i;
         len_mem[wr_ptr_reg]  <= bus.desc_len_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         qcount_reg <= 5'd0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   qcount_reg <= qcount_reg + 5'd1;
            2'b01:   qcount_reg <= qcount_reg - 5'd1;
            default: qcount_reg <= qcount_reg;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg   <= IDLE;
         addr_reg    <= '0;
         len_reg     <= 11'd0;
         words_reg   <= 10'd0;
         idx_reg     <= 10'd0;
         src_adr_reg <= '0;
         src_stb_reg <= 1'b0;
         mac_adr_reg <= 13'd0;
         mac_dat_reg <= 32'd0;
         mac_stb_reg <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         err_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (qcount_reg != 5'd0) begin
                  addr_reg  <= addr_mem[rd_ptr_reg];
                  len_reg   <= len_mem[rd_ptr_reg];
                  busy_reg  <= 1'b1;
                  state_reg <= CHECK;
               end
            end
            CHECK: begin
               if (len_reg == 11'd0 || len_reg > 11'd2044) begin
                  err_reg   <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end else begin
                  words_reg <= len_plus[11:2];
                  idx_reg   <= 10'd0;
                  state_reg <= WAITMAC;
               end
            end
            WAITMAC: begin
               if (bus.mac_txempty_i) begin
                  src_adr_reg <= addr_reg + SRC_AW'(idx_reg);
                  src_stb_reg <= 1'b1;
                  state_reg   <= RD;
               end
            end
            RD: begin
               if (src_stb_reg && bus.src_ack_i) begin
                  src_stb_reg <= 1'b0;
                  mac_adr_reg <= {1'b0, idx_next, 2'b00};
                  mac_dat_reg <= bus.src_dat_i;
                  mac_stb_reg <= 1'b1;
                  state_reg   <= WR;
               end
            end
            WR: begin
               if (mac_stb_reg && bus.mac_ack_i) begin
                  mac_stb_reg <= 1'b0;
                  idx_reg     <= idx_next;
                  if (idx_next == words_reg) begin
                     state_reg <= START;
                  end else begin
                     src_adr_reg <= addr_reg + SRC_AW'(idx_next);
                     src_stb_reg <= 1'b1;
                     state_reg   <= RD;
                  end
               end
            end
            START: begin
               // One idle bus cycle after the last data write before the length write strobes.
               if (!mac_stb_reg) begin
                  mac_adr_reg <= 13'd0;
                  mac_dat_reg <= {21'd0, len_reg};
                  mac_stb_reg <= 1'b1;
               end else if (bus.mac_ack_i) begin
                  mac_stb_reg <= 1'b0;
                  state_reg   <= WAITLO;
               end
            end
            WAITLO: begin
               if (!bus.mac_txempty_i) state_reg <= WAITHI;
            end
            WAITHI: begin
               if (bus.mac_txempty_i) begin
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.desc_ready_o = desc_ready;
   assign bus.src_adr_o    = src_adr_reg;
   assign bus.src_stb_o    = src_stb_reg;
   assign bus.mac_adr_o    = mac_adr_reg;
   assign bus.mac_dat_o    = mac_dat_reg;
   assign bus.mac_sel_o    = 4'b1111;
   assign bus.mac_stb_o    = mac_stb_reg;
   assign bus.mac_we_o     = 1'b1;
   assign bus.busy_o       = busy_reg;
   assign bus.done_o       = done_reg;
   assign bus.err_o        = err_reg;
   assign bus.qcount_o     = qcount_reg;
endmodule

// File: tb/tb_mac_txq.sv
// Scoreboard bench for mac_txq: stimulus queues expected MAC writes / done / err events,
// a monitor pops and compares them as the DUT produces them.
module tb_mac_txq;
   localparam int QDEPTH = 4;
   localparam int SRC_AW = 11;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mac_txq_if #(.SRC_AW(SRC_AW)) bus ();
   mac_txq #(.QDEPTH(QDEPTH), .SRC_AW(SRC_AW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

   typedef struct {
      int          kind;   // 0 = MAC write, 1 = done pulse, 2 = err pulse
      logic [12:0] adr;
      logic [31:0] dat;
   } ev_t;

   ev_t  exp_q[$];
   int   tests = 0;
   int   fails = 0;

   int   src_mode = 0, mac_mode = 0;
   int   src_cnt = 0, src_dly = 0, mac_cnt = 0, mac_dly = 0;
   bit   src_active = 0, mac_active = 0;
   logic mac_idle = 1'b1;
   int   mac_busy_cnt = 0;
   bit   mac_hold = 1'b0;

   assign bus.mac_txempty_i = mac_idle && !mac_hold;

   function automatic logic [31:0] src_word(input logic [10:0] a);
      return 32'hC0DE_0000 + {21'd0, a};
   endfunction

   // Source memory slave with optional random wait states.
   always @(negedge clk) begin
      if (bus.src_stb_o && !rst) begin
         if (!src_active) begin
            src_active = 1;
            src_cnt    = 0;
            src_dly    = (src_mode != 0) ? int'($urandom_range(0, 3)) : 0;
         end
         if (src_cnt >= src_dly) begin
            bus.src_ack_i = 1'b1;
            bus.src_dat_i = src_word(bus.src_adr_o);
            src_active    = 0;
         end else begin
            bus.src_ack_i = 1'b0;
            src_cnt++;
         end
      end else begin
         bus.src_ack_i = 1'b0;
         bus.src_dat_i = 32'd0;
         src_active    = 0;
      end
   end

   // MAC register slave: mode 0 zero-wait, 1 random 0..3, 2 fixed 20 wait states.
   always @(negedge clk) begin
      if (bus.mac_stb_o && !rst) begin
         if (!mac_active) begin
            mac_active = 1;
            mac_cnt    = 0;
            mac_dly    = (mac_mode == 2) ? 20 : (mac_mode == 1) ? int'($urandom_range(0, 3)) : 0;
         end
         if (mac_cnt >= mac_dly) begin
            bus.mac_ack_i = 1'b1;
            mac_active    = 0;
         end else begin
            bus.mac_ack_i = 1'b0;
            mac_cnt++;
         end
      end else begin
         bus.mac_ack_i = 1'b0;
         mac_active    = 0;
      end
   end

   task automatic check_ev(input int kind, input logic [12:0] adr, input logic [31:0] dat);
      ev_t e;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL unexpected_event: got kind=%0d adr=%0h dat=%0h, required no event", kind, adr, dat);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.adr !== adr || e.dat !== dat) begin
            fails++;
            $display("FAIL event: got kind=%0d adr=%0h dat=%0h, required kind=%0d adr=%0h dat=%0h",
                     kind, adr, dat, e.kind, e.adr, e.dat);
         end else begin
            $display("[TB] event kind=%0d adr=%0h dat=%0h ok", kind, adr, dat);
         end
      end
   endtask

   // Monitor plus transmitter model: a length write makes the MAC busy for a few cycles.
   always @(negedge clk) begin
      #1;
      if (rst) begin
         mac_idle     = 1'b1;
         mac_busy_cnt = 0;
      end else begin
         if (!mac_idle) begin
            if (mac_busy_cnt == 0) mac_idle = 1'b1;
            else mac_busy_cnt--;
         end
         if (bus.src_stb_o || bus.mac_stb_o) begin
            tests++;
            if (bus.src_stb_o && bus.mac_stb_o) begin
               fails++;
               $display("FAIL strobe_overlap: got src_stb=1 mac_stb=1, required at most one");
            end
         end
         if (bus.mac_stb_o && bus.mac_ack_i) begin
            tests++;
            if (bus.mac_sel_o !== 4'hF || bus.mac_we_o !== 1'b1) begin
               fails++;
               $display("FAIL mac_sel_we: got sel=%0h we=%0b, required sel=f we=1", bus.mac_sel_o, bus.mac_we_o);
            end
            check_ev(0, bus.mac_adr_o, bus.mac_dat_o);
            if (bus.mac_adr_o == 13'd0) begin
               mac_idle     = 1'b0;
               mac_busy_cnt = 4;
            end
         end
         if (bus.done_o) check_ev(1, 13'd0, 32'd0);
         if (bus.err_o)  check_ev(2, 13'd0, 32'd0);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end else begin
         $display("[TB] %s = %0h ok", name, act);
      end
   endtask

   task automatic exp_wr(input logic [12:0] adr, input logic [31:0] dat);
      exp_q.push_back('{0, adr, dat});
   endtask

   task automatic exp_done();
      exp_q.push_back('{1, 13'd0, 32'd0});
   endtask

   task automatic exp_err();
      exp_q.push_back('{2, 13'd0, 32'd0});
   endtask

   task automatic exp_frame(input logic [10:0] a, input logic [10:0] l);
      int words;
      words = (int'(l) + 3) / 4;
      for (int w = 0; w < words; w++) begin
         logic [10:0] sa;
         sa = a + 11'(w);
         exp_wr(13'((w + 1) * 4), src_word(sa));
      end
      exp_wr(13'd0, {21'd0, l});
      exp_done();
   endtask

   task automatic push(input logic [10:0] a, input logic [10:0] l);
      int t;
      t = 0;
      @(negedge clk);
      bus.desc_valid_i = 1'b1;
      bus.desc_addr_i  = a;
      bus.desc_len_i   = l;
      while (!bus.desc_ready_o && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (!bus.desc_ready_o) begin
         tests++;
         fails++;
         $display("FAIL push_timeout: got desc_ready=0 after %0d cycles, required 1", t);
      end
      @(posedge clk);
      #1;
      bus.desc_valid_i = 1'b0;
      $display("[TB] push addr=%0h len=%0d", a, l);
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || bus.busy_o || bus.qcount_o != 5'd0) && t < 4000) begin
         @(negedge clk);
         t++;
      end
      check({name, "_drained"}, {31'd0, (t >= 4000)}, 32'd0);
   endtask

   initial begin
      bus.desc_valid_i = 1'b0;
      bus.desc_addr_i  = '0;
      bus.desc_len_i   = 11'd0;
      #1;
      check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
      check("rst_mac_stb", {31'd0, bus.mac_stb_o}, 32'd0);
      check("rst_src_stb", {31'd0, bus.src_stb_o}, 32'd0);
      check("rst_qcount", {27'd0, bus.qcount_o}, 32'd0);
      check("rst_ready", {31'd0, bus.desc_ready_o}, 32'd1);
      check("rst_done_err", {30'd0, bus.done_o, bus.err_o}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Basic two-word frame with pop-to-strobe latency.
      exp_wr(13'h004, 32'hC0DE_0010);
      exp_wr(13'h008, 32'hC0DE_0011);
      exp_wr(13'h000, 32'd8);
      exp_done();
      push(11'h010, 11'd8);
      @(negedge clk);
      check("lat_qcount_pushed", {27'd0, bus.qcount_o}, 32'd1);
      @(negedge clk);
      check("lat_qcount_popped", {27'd0, bus.qcount_o}, 32'd0);
      check("lat_busy", {31'd0, bus.busy_o}, 32'd1);
      @(negedge clk);
      check("lat_src_stb_early", {31'd0, bus.src_stb_o}, 32'd0);
      @(negedge clk);
      check("lat_src_stb", {31'd0, bus.src_stb_o}, 32'd1);
      check("lat_src_adr", {21'd0, bus.src_adr_o}, 32'h010);
      wait_idle("len8");

      // Partial last word, then single-byte frame.
      exp_wr(13'h004, 32'hC0DE_0020);
      exp_wr(13'h008, 32'hC0DE_0021);
      exp_wr(13'h000, 32'd5);
      exp_done();
      exp_wr(13'h004, 32'hC0DE_0040);
      exp_wr(13'h000, 32'd1);
      exp_done();
      push(11'h020, 11'd5);
      push(11'h040, 11'd1);
      wait_idle("len5_len1");

      // Rejected lengths.
      exp_err();
      exp_err();
      push(11'h030, 11'd0);
      push(11'h030, 11'd2045);
      wait_idle("reject");
      check("reject_qcount", {27'd0, bus.qcount_o}, 32'd0);

      // Source address wrap with random wait states.
      src_mode = 1;
      mac_mode = 1;
      exp_wr(13'h004, 32'hC0DE_07FF);
      exp_wr(13'h008, 32'hC0DE_0000);
      exp_wr(13'h000, 32'd8);
      exp_done();
      push(11'h7FF, 11'd8);
      wait_idle("wrap");

      // Queue full: first frame parked in WAITMAC, four more fill the FIFO, sixth stalls.
      mac_hold = 1'b1;
      exp_frame(11'h100, 11'd4);
      exp_frame(11'h110, 11'd8);
      exp_frame(11'h120, 11'd3);
      exp_frame(11'h130, 11'd12);
      exp_frame(11'h140, 11'd7);
      exp_frame(11'h150, 11'd1);
      push(11'h100, 11'd4);
      push(11'h110, 11'd8);
      push(11'h120, 11'd3);
      push(11'h130, 11'd12);
      push(11'h140, 11'd7);
      fork
         push(11'h150, 11'd1);
         begin
            repeat (3) @(negedge clk);
            check("full_ready", {31'd0, bus.desc_ready_o}, 32'd0);
            check("full_qcount", {27'd0, bus.qcount_o}, 32'd4);
            mac_hold = 1'b0;
         end
      join
      wait_idle("full");

      // Reset while a MAC write is waiting for its ack.
      src_mode = 0;
      mac_mode = 2;
      push(11'h200, 11'd16);
      push(11'h300, 11'd8);
      push(11'h310, 11'd8);
      begin
         int t;
         t = 0;
         while (!bus.mac_stb_o && t < 200) begin
            @(negedge clk);
            t++;
         end
         check("midframe_reached_wr", {31'd0, bus.mac_stb_o}, 32'd1);
      end
      check("midframe_qcount", {27'd0, bus.qcount_o}, 32'd2);
      #2;
      rst = 1'b1;
      #1;
      check("async_mac_stb", {31'd0, bus.mac_stb_o}, 32'd0);
      check("async_qcount", {27'd0, bus.qcount_o}, 32'd0);
      check("async_busy", {31'd0, bus.busy_o}, 32'd0);
      check("async_ready", {31'd0, bus.desc_ready_o}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      mac_mode = 0;
      repeat (60) @(negedge clk);
      check("post_reset_quiet", {27'd0, bus.qcount_o, bus.busy_o, bus.src_stb_o, bus.mac_stb_o}, 32'd0);

      // Recovery after reset.
      exp_wr(13'h004, 32'hC0DE_0010);
      exp_wr(13'h000, 32'd4);
      exp_done();
      push(11'h010, 11'd4);
      wait_idle("recover");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation time limit, required completion");
      $fatal(1, "watchdog expired");
   end
endmodule
